// File: rtl/output_requant_fifo_if.sv
// ----------------------------------------------------------------------------
// output_requant_fifo_if
//   Bundles both streaming sides of output_requant_fifo:
//     in_*  : result + (x,y,ch) tag from the conv core (valid/ready, ready is
//             advisory: a valid sample while ready is low is dropped)
//     out_* : requantized value + tag toward the host (valid/ready, AXI-style)
//   Modports:
//     master : producer/consumer side (drives in_*, out_ready)
//     slave  : the FIFO itself (drives in_ready, out_valid, out_data/x/y/ch)
// ----------------------------------------------------------------------------
interface output_requant_fifo_if #(
  parameter int ACC_WIDTH     = 32,
  parameter int IO_DATA_WIDTH = 16,
  parameter int X_W           = 10,
  parameter int Y_W           = 10,
  parameter int CH_W          = 6
);
  // Input side
  logic                     in_valid;
  logic                     in_ready;
  logic [ACC_WIDTH-1:0]     in_data;
  logic [X_W-1:0]           in_x;
  logic [Y_W-1:0]           in_y;
  logic [CH_W-1:0]          in_ch;

  // Output side
  logic                     out_valid;
  logic                     out_ready;
  logic [IO_DATA_WIDTH-1:0] out_data;
  logic [X_W-1:0]           out_x;
  logic [Y_W-1:0]           out_y;
  logic [CH_W-1:0]          out_ch;

  modport master (
    output in_valid, in_data, in_x, in_y, in_ch, out_ready,
    input  in_ready, out_valid, out_data, out_x, out_y, out_ch
  );

  modport slave (
    input  in_valid, in_data, in_x, in_y, in_ch, out_ready,
    output in_ready, out_valid, out_data, out_x, out_y, out_ch
  );
endinterface

// File: rtl/output_requant_fifo.sv
// ----------------------------------------------------------------------------
// output_requant_fifo
//   Requantizes each finished MAC result (rounding arithmetic right shift,
//   then saturation to the signed IO width), registers it with its tag in a
//   one-entry stage, then buffers it in a small FIFO drained over valid/ready.
//   Decouples the non-stallable core output from a host that back-pressures.
// Ports:
//   clk              clock, all state on rising edge
//   arst_in          asynchronous active-high reset
//   bus (slave)      in_* from the core, out_* toward the host
//   clear_overflow_i synchronous pulse, clears the sticky overflow flag
//   count_o          entries in the FIFO (stage register not included)
//   overflow_o       sticky: a sample was dropped because in_ready was low
// ----------------------------------------------------------------------------
module output_requant_fifo #(
  parameter int ACC_WIDTH          = 32,
  parameter int IO_DATA_WIDTH      = 16,
  parameter int OUTPUT_SHIFT       = 0,
  parameter int FIFO_DEPTH         = 4,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  localparam int X_W   = $clog2(FEATURE_MAP_WIDTH),
  localparam int Y_W   = $clog2(FEATURE_MAP_HEIGHT),
  localparam int CH_W  = $clog2(OUTPUT_NB_CHANNELS),
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 arst_in,
  output_requant_fifo_if.slave bus,
  input  logic                 clear_overflow_i,
  output logic [CNT_W-1:0]     count_o,
  output logic                 overflow_o
);

  // --------------------------------------------------------------------------
  // Requantization (combinational, on the incoming sample)
  // --------------------------------------------------------------------------
  // One guard bit so the rounding add can never wrap.
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH + 2 - IO_DATA_WIDTH){1'b0}}, {(IO_DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH + 2 - IO_DATA_WIDTH){1'b1}}, {(IO_DATA_WIDTH - 1){1'b0}}};

  logic signed [ACC_WIDTH:0]  acc_ext;
  logic signed [ACC_WIDTH:0]  shifted;
  logic [IO_DATA_WIDTH-1:0]   requant;

  assign acc_ext = {bus.in_data[ACC_WIDTH-1], bus.in_data};

  generate
    if (OUTPUT_SHIFT > 0) begin : g_round
      // Adding half an LSB before the arithmetic shift rounds half up.
      localparam logic signed [ACC_WIDTH:0] ROUND_BIAS =
        (ACC_WIDTH + 1)'(1) << (OUTPUT_SHIFT - 1);
      logic signed [ACC_WIDTH:0] biased;
      assign biased  = acc_ext + ROUND_BIAS;
      assign shifted = biased >>> OUTPUT_SHIFT;
    end else begin : g_noround
      assign shifted = acc_ext;
    end
  endgenerate

  always_comb begin
    requant = shifted[IO_DATA_WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      requant = {1'b0, {(IO_DATA_WIDTH - 1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      requant = {1'b1, {(IO_DATA_WIDTH - 1){1'b0}}};
    end
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                     pipe_valid_q, pipe_valid_d;
  logic [IO_DATA_WIDTH-1:0] pipe_data_q,  pipe_data_d;
  logic [X_W-1:0]           pipe_x_q,     pipe_x_d;
  logic [Y_W-1:0]           pipe_y_q,     pipe_y_d;
  logic [CH_W-1:0]          pipe_ch_q,    pipe_ch_d;

  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q,  count_d;
  logic                     overflow_q, overflow_d;

  // Registered copy of the FIFO head; holds the last value once empty.
  logic [IO_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [X_W-1:0]           out_x_q,    out_x_d;
  logic [Y_W-1:0]           out_y_q,    out_y_d;
  logic [CH_W-1:0]          out_ch_q,   out_ch_d;

  logic [IO_DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [X_W-1:0]           mem_x_q    [FIFO_DEPTH];
  logic [Y_W-1:0]           mem_y_q    [FIFO_DEPTH];
  logic [CH_W-1:0]          mem_ch_q   [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  logic [CNT_W:0]   occupancy;
  logic             in_ready;
  logic             accept;
  logic             drop;
  logic             push;
  logic             pop;
  logic             out_valid;
  logic [PTR_W-1:0] rd_next_slot;

  // Credit counts the stage register as occupied and ignores a pop in the
  // same cycle, so in_ready depends on registers only (no out_ready path).
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, pipe_valid_q};
  assign in_ready  = occupancy < (CNT_W + 1)'(FIFO_DEPTH);

  assign out_valid    = (count_q != '0);
  assign accept       = bus.in_valid & in_ready;
  assign drop         = bus.in_valid & ~in_ready;
  assign push         = pipe_valid_q;
  assign pop          = out_valid & bus.out_ready;
  assign rd_next_slot = rd_ptr_q + PTR_W'(1);

  always_comb begin
    pipe_valid_d = accept;
    pipe_data_d  = pipe_data_q;
    pipe_x_d     = pipe_x_q;
    pipe_y_d     = pipe_y_q;
    pipe_ch_d    = pipe_ch_q;
    if (accept) begin
      pipe_data_d = requant;
      pipe_x_d    = bus.in_x;
      pipe_y_d    = bus.in_y;
      pipe_ch_d   = bus.in_ch;
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    // Set wins over clear when both happen in the same cycle.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow_i) begin
      overflow_d = 1'b0;
    end

    // Head update: when the FIFO is (or is about to be) empty the entry being
    // written becomes the head directly; otherwise a pop exposes the next
    // stored slot. Without a pop the head holds.
    out_data_d = out_data_q;
    out_x_d    = out_x_q;
    out_y_d    = out_y_q;
    out_ch_d   = out_ch_q;
    if ((count_q == '0) || (pop && (count_q == CNT_W'(1)))) begin
      if (push) begin
        out_data_d = pipe_data_q;
        out_x_d    = pipe_x_q;
        out_y_d    = pipe_y_q;
        out_ch_d   = pipe_ch_q;
      end
    end else if (pop) begin
      out_data_d = mem_data_q[rd_next_slot];
      out_x_d    = mem_x_q[rd_next_slot];
      out_y_d    = mem_y_q[rd_next_slot];
      out_ch_d   = mem_ch_q[rd_next_slot];
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      pipe_valid_q <= 1'b0;
      pipe_data_q  <= '0;
      pipe_x_q     <= '0;
      pipe_y_q     <= '0;
      pipe_ch_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      out_data_q   <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_ch_q     <= '0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_data_q  <= pipe_data_d;
      pipe_x_q     <= pipe_x_d;
      pipe_y_q     <= pipe_y_d;
      pipe_ch_q    <= pipe_ch_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      out_data_q   <= out_data_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_ch_q     <= out_ch_d;
    end
  end

  // Storage needs no reset: validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= pipe_data_q;
      mem_x_q[wr_ptr_q]    <= pipe_x_q;
      mem_y_q[wr_ptr_q]    <= pipe_y_q;
      mem_ch_q[wr_ptr_q]   <= pipe_ch_q;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_ch    = out_ch_q;
  assign count_o       = count_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_output_requant_fifo.sv
// ----------------------------------------------------------------------------
// tb_output_requant_fifo
//   Directed + randomized checks of output_requant_fifo. Two instances share
//   clock and reset: dut0 with OUTPUT_SHIFT=0, dut4 with OUTPUT_SHIFT=4.
//   Outputs are sampled and inputs driven on the falling edge.
// ----------------------------------------------------------------------------
module tb_output_requant_fifo;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic arst_in;
  always #5 clk = ~clk;

  output_requant_fifo_if #(.ACC_WIDTH(32), .IO_DATA_WIDTH(16), .X_W(XW), .Y_W(YW), .CH_W(CW)) bus0 ();
  output_requant_fifo_if #(.ACC_WIDTH(32), .IO_DATA_WIDTH(16), .X_W(XW), .Y_W(YW), .CH_W(CW)) bus4 ();

  logic       clr0, clr4;
  logic [2:0] count0, count4;
  logic       ov0, ov4;

  output_requant_fifo #(.OUTPUT_SHIFT(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .arst_in(arst_in), .bus(bus0.slave),
    .clear_overflow_i(clr0), .count_o(count0), .overflow_o(ov0)
  );

  output_requant_fifo #(.OUTPUT_SHIFT(4), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .arst_in(arst_in), .bus(bus4.slave),
    .clear_overflow_i(clr4), .count_o(count4), .overflow_o(ov4)
  );

  int checks = 0;
  int passed = 0;

  // Reference requantization for the SHIFT=4 instance (random test only).
  function automatic logic [15:0] rq4(input logic [31:0] d);
    longint t;
    t = (longint'($signed(d)) + 64'sd8) >>> 4;
    if (t > 64'sd32767)  return 16'h7FFF;
    if (t < -64'sd32768) return 16'h8000;
    return t[15:0];
  endfunction

  task automatic idle_all();
    bus0.in_valid = 0; bus0.in_data = '0; bus0.in_x = '0; bus0.in_y = '0; bus0.in_ch = '0; bus0.out_ready = 0;
    bus4.in_valid = 0; bus4.in_data = '0; bus4.in_x = '0; bus4.in_y = '0; bus4.in_ch = '0; bus4.out_ready = 0;
    clr0 = 0; clr4 = 0;
  endtask

  task automatic test_reset();
    idle_all();
    arst_in = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({bus4.out_valid, count4, ov4} !== 5'b0) $display("FAIL reset_state: valid/count/ov=%b required 00000", {bus4.out_valid, count4, ov4}); else passed++;
    checks++; if (bus4.out_data !== 16'h0 || bus0.out_data !== 16'h0) $display("FAIL reset_data: %h/%h required 0000", bus4.out_data, bus0.out_data); else passed++;
    arst_in = 1'b0;
    @(negedge clk);
    checks++; if (bus4.in_ready !== 1'b1 || bus0.in_ready !== 1'b1) $display("FAIL reset_ready: %b/%b required 1", bus4.in_ready, bus0.in_ready); else passed++;
    $display("reset released: count=%0d in_ready=%b", count4, bus4.in_ready);
  endtask

  task automatic test_passthrough();
    bus0.in_valid = 1; bus0.in_data = 32'sd100; bus0.in_x = 3; bus0.in_y = 5; bus0.in_ch = 7; bus0.out_ready = 1;
    @(negedge clk);
    bus0.in_valid = 0;
    checks++; if (bus0.out_valid !== 1'b0 || count0 !== 3'd0) $display("FAIL pass_stage1: valid=%b count=%0d required 0/0", bus0.out_valid, count0); else passed++;
    @(negedge clk);
    checks++; if (bus0.out_valid !== 1'b1 || count0 !== 3'd1) $display("FAIL pass_valid: valid=%b count=%0d required 1/1", bus0.out_valid, count0); else passed++;
    checks++; if ({bus0.out_data, bus0.out_x, bus0.out_y, bus0.out_ch} !== {16'd100, 10'd3, 10'd5, 6'd7})
      $display("FAIL pass_data: %0d (%0d,%0d,%0d) required 100 (3,5,7)", bus0.out_data, bus0.out_x, bus0.out_y, bus0.out_ch); else passed++;
    $display("pass: out=%0d tag=(%0d,%0d,%0d)", $signed(bus0.out_data), bus0.out_x, bus0.out_y, bus0.out_ch);
    @(negedge clk);
    checks++; if (bus0.out_valid !== 1'b0 || bus0.out_data !== 16'd100) $display("FAIL pass_hold: valid=%b data=%0d required 0/100", bus0.out_valid, bus0.out_data); else passed++;
    bus0.out_ready = 0;
  endtask

  task automatic test_rounding();
    logic [31:0] din  [6];
    logic [15:0] dexp [6];
    int sent = 0;
    int got  = 0;
    din  = '{32'd40, 32'hFFFF_FFD8, 32'd7, 32'd8, 32'h7FFF_FFFF, 32'h8000_0000};
    dexp = '{16'd3, 16'hFFFE, 16'd0, 16'd1, 16'h7FFF, 16'h8000};
    bus4.out_ready = 1;
    for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
      if (bus4.out_valid === 1'b1) begin
        checks++; if (bus4.out_data !== dexp[got] || bus4.out_x !== 10'(got))
          $display("FAIL round_%0d: data=%h x=%0d required %h x=%0d", got, bus4.out_data, bus4.out_x, dexp[got], got); else passed++;
        $display("round: in=%h out=%0d", din[got], $signed(bus4.out_data));
        got++;
      end
      if (sent < 6) begin
        bus4.in_valid = 1; bus4.in_data = din[sent]; bus4.in_x = 10'(sent); sent++;
      end else begin
        bus4.in_valid = 0;
      end
      @(negedge clk);
    end
    checks++; if (got != 6) $display("FAIL round_timeout: got %0d outputs required 6", got); else passed++;
    bus4.in_valid = 0; bus4.out_ready = 0;
  endtask

  task automatic test_overflow();
    logic ready_exp [6];
    ready_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bus4.out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      checks++; if (bus4.in_ready !== ready_exp[i]) $display("FAIL ovf_ready_%0d: %b required %b", i, bus4.in_ready, ready_exp[i]); else passed++;
      bus4.in_valid = 1; bus4.in_data = 32'(16 * (i + 1)); bus4.in_x = 10'(i);
      @(negedge clk);
    end
    bus4.in_valid = 0;
    @(negedge clk);
    checks++; if (count4 !== 3'd4 || ov4 !== 1'b1 || bus4.in_ready !== 1'b0)
      $display("FAIL ovf_full: count=%0d ov=%b ready=%b required 4/1/0", count4, ov4, bus4.in_ready); else passed++;
    // Clear and drop in the same cycle: the drop must win.
    clr4 = 1; bus4.in_valid = 1; bus4.in_data = 32'd999;
    @(negedge clk);
    clr4 = 0; bus4.in_valid = 0;
    checks++; if (ov4 !== 1'b1 || count4 !== 3'd4) $display("FAIL ovf_setwins: ov=%b count=%0d required 1/4", ov4, count4); else passed++;
    checks++; if (bus4.out_data !== 16'd1) $display("FAIL ovf_hold: data=%0d required 1", bus4.out_data); else passed++;
    bus4.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 16'(i + 1) || bus4.out_x !== 10'(i))
        $display("FAIL ovf_drain_%0d: valid=%b data=%0d x=%0d required 1/%0d/%0d", i, bus4.out_valid, bus4.out_data, bus4.out_x, i + 1, i); else passed++;
      $display("drain: out=%0d x=%0d", bus4.out_data, bus4.out_x);
      @(negedge clk);
    end
    checks++; if (bus4.out_valid !== 1'b0 || count4 !== 3'd0) $display("FAIL ovf_empty: valid=%b count=%0d required 0/0", bus4.out_valid, count4); else passed++;
    bus4.out_ready = 0;
    clr4 = 1;
    @(negedge clk);
    clr4 = 0;
    checks++; if (ov4 !== 1'b0) $display("FAIL ovf_clear: ov=%b required 0", ov4); else passed++;
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got  = 0;
    int bad  = 0;
    bus4.out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      bus4.in_valid = 1; bus4.in_data = 32'(16 * (sent + 1)); sent++;
      @(negedge clk);
    end
    bus4.in_valid = 0;
    @(negedge clk);
    checks++; if (count4 !== 3'd4 || bus4.in_ready !== 1'b0) $display("FAIL b2b_full: count=%0d ready=%b required 4/0", count4, bus4.in_ready); else passed++;
    bus4.out_ready = 1;
    for (int cyc = 0; cyc < 100 && got < 20; cyc++) begin
      if (bus4.out_valid === 1'b1) begin
        if (bus4.out_data !== 16'(got + 1)) begin
          bad++;
          $display("FAIL b2b_order_%0d: data=%0d required %0d", got, bus4.out_data, got + 1);
        end
        got++;
      end
      if (bus4.in_ready === 1'b1 && sent < 20) begin
        bus4.in_valid = 1; bus4.in_data = 32'(16 * (sent + 1)); sent++;
      end else begin
        bus4.in_valid = 0;
      end
      @(negedge clk);
    end
    bus4.in_valid = 0; bus4.out_ready = 0;
    $display("b2b: sent=%0d received=%0d", sent, got);
    checks++; if (got != 20 || bad != 0) $display("FAIL b2b_stream: got=%0d bad=%0d required 20/0", got, bad); else passed++;
    checks++; if (ov4 !== 1'b0 || count4 !== 3'd0) $display("FAIL b2b_nodrop: ov=%b count=%0d required 0/0", ov4, count4); else passed++;
  endtask

  task automatic test_random();
    logic [41:0] q [$];
    int  mc  = 0;
    bit  mp  = 0;
    bit  mov = 0;
    bit  iv, ordy, clr, acc, drp, pp, er;
    logic [31:0] d;
    logic [9:0]  x, y;
    logic [5:0]  ch;
    int  pops = 0;
    arst_in = 1; @(negedge clk); arst_in = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      er = (mc + int'(mp)) < 4;
      checks++; if ({bus4.in_ready, bus4.out_valid, ov4, count4} !== {er, mc > 0, mov, 3'(mc)})
        $display("FAIL rnd_state_%0d: ready/valid/ov/count=%b required %b", cyc, {bus4.in_ready, bus4.out_valid, ov4, count4}, {er, mc > 0, mov, 3'(mc)}); else passed++;
      iv = $urandom_range(0, 99) < 60; ordy = $urandom_range(0, 99) < 50; clr = $urandom_range(0, 99) < 3;
      d = $urandom; x = 10'($urandom); y = 10'($urandom); ch = 6'($urandom);
      acc = iv && er; drp = iv && !er; pp = (mc > 0) && ordy;
      if (pp && q.size() > 0) begin
        checks++; if ({bus4.out_data, bus4.out_x, bus4.out_y, bus4.out_ch} !== q[0])
          $display("FAIL rnd_data_%0d: %h required %h", pops, {bus4.out_data, bus4.out_x, bus4.out_y, bus4.out_ch}, q[0]); else passed++;
        void'(q.pop_front());
        pops++;
      end
      if (acc) q.push_back({rq4(d), x, y, ch});
      mc  = mc + int'(mp) - int'(pp);
      mp  = acc;
      mov = drp ? 1'b1 : (clr ? 1'b0 : mov);
      bus4.in_valid = iv; bus4.in_data = d; bus4.in_x = x; bus4.in_y = y; bus4.in_ch = ch;
      bus4.out_ready = ordy; clr4 = clr;
      @(negedge clk);
    end
    idle_all();
    $display("random: pops=%0d", pops);
    checks++; if (pops < 200) $display("FAIL rnd_activity: pops=%0d required >=200", pops); else passed++;
  endtask

  task automatic test_reset_midstream();
    arst_in = 1; @(negedge clk); arst_in = 0;
    bus4.out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      bus4.in_valid = 1; bus4.in_data = 32'(16 * (i + 1));
      @(negedge clk);
    end
    bus4.in_valid = 0;
    checks++; if (count4 !== 3'd3) $display("FAIL mid_count: count=%0d required 3", count4); else passed++;
    #1 arst_in = 1;
    #1;
    checks++; if (bus4.out_valid !== 1'b0 || count4 !== 3'd0) $display("FAIL mid_reset: valid=%b count=%0d required 0/0", bus4.out_valid, count4); else passed++;
    @(negedge clk);
    arst_in = 0;
    bus4.in_valid = 1; bus4.in_data = 32'd144; bus4.in_x = 1; bus4.in_y = 2; bus4.in_ch = 3; bus4.out_ready = 1;
    @(negedge clk);
    bus4.in_valid = 0;
    checks++; if (bus4.out_valid !== 1'b0) $display("FAIL mid_noghost: valid=%b required 0", bus4.out_valid); else passed++;
    @(negedge clk);
    checks++; if ({bus4.out_valid, bus4.out_data, bus4.out_x, bus4.out_y, bus4.out_ch, count4} !== {1'b1, 16'd9, 10'd1, 10'd2, 6'd3, 3'd1})
      $display("FAIL mid_push: valid=%b data=%0d (%0d,%0d,%0d) count=%0d required 1/9 (1,2,3) 1",
               bus4.out_valid, bus4.out_data, bus4.out_x, bus4.out_y, bus4.out_ch, count4); else passed++;
    $display("post-reset push: out=%0d", bus4.out_data);
    @(negedge clk);
    checks++; if (bus4.out_valid !== 1'b0 || count4 !== 3'd0) $display("FAIL mid_alone: valid=%b count=%0d required 0/0", bus4.out_valid, count4); else passed++;
    bus4.out_ready = 0;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_rounding();
    test_overflow();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
